// File: rtl/svm_label_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : svm_label_packer                                           |
// | Description : Packs the classifier's 1-bit label stream LSB-first into   |
// |               PACK_W-bit words, buffers them in a first-word-fall-       |
// |               through FIFO and presents them on a valid/ready port.      |
// |               Optional positive-label counter enabled by the macro       |
// |               SVM_PACK_POSCNT_EN (pos_count tied to 0 otherwise).        |
// | Ports       : clk, reset (sync, active-low)                              |
// |               DE_in/label    - label stream from the classifier          |
// |               flush          - emit current partial word                 |
// |               out_data/out_count/out_valid/out_ready - FIFO head port    |
// |               overflow       - sticky word-drop flag                     |
// |               pos_count      - saturating count of accepted 1-labels     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module svm_label_packer #(
  parameter int PACK_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BW     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          DE_in,
  input  logic                          label,
  input  logic                          flush,
  output logic [PACK_W-1:0]             out_data,
  output logic [$clog2(PACK_W+1)-1:0]   out_count,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic [CNT_BW-1:0]             pos_count
);

  localparam int FILL_W = $clog2(PACK_W);
  localparam int CNT_W  = $clog2(PACK_W + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);

  // Packer state
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PACK_W-1:0] pack_q, pack_d;
  logic [PACK_W-1:0] push_data;
  logic [CNT_W-1:0]  push_cnt;
  logic              push;
  logic              full_word;

  // FIFO state
  logic [PACK_W-1:0] mem_data_q [FIFO_DEPTH];
  logic [CNT_W-1:0]  mem_cnt_q  [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       occ_q;
  logic              overflow_q;
  logic              fifo_full;
  logic              pop;
  logic              do_push;
  logic              drop;

  // push_data is the current word with the coincident label merged in; it
  // serves both as the enqueued word and as the next packer contents.
  always_comb begin
    pack_d    = pack_q;
    fill_d    = fill_q;
    push_data = pack_q;
    push_cnt  = CNT_W'(fill_q);
    push      = 1'b0;
    full_word = DE_in && (fill_q == FILL_W'(PACK_W - 1));
    if (DE_in) begin
      push_data[fill_q] = label;
      push_cnt          = CNT_W'(fill_q) + CNT_W'(1);
    end
    // A full word takes priority; a coincident flush adds nothing more.
    if (full_word) begin
      push = 1'b1;
    end else if (flush && ((fill_q != '0) || DE_in)) begin
      push = 1'b1;
    end
    if (push) begin
      pack_d = '0;
      fill_d = '0;
    end else if (DE_in) begin
      pack_d = push_data;
      fill_d = fill_q + FILL_W'(1);
    end
  end

  assign out_valid = (occ_q != '0);
  assign fifo_full = (occ_q == (AW+1)'(FIFO_DEPTH));
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_push   = push && (!fifo_full || pop);
  assign drop      = push && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_q     <= '0;
      pack_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      pack_q <= pack_d;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      case ({do_push, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem_data_q[wr_ptr_q] <= push_data;
      mem_cnt_q[wr_ptr_q]  <= push_cnt;
    end
  end

  assign out_data  = out_valid ? mem_data_q[rd_ptr_q] : '0;
  assign out_count = out_valid ? mem_cnt_q[rd_ptr_q]  : '0;
  assign overflow  = overflow_q;

`ifdef SVM_PACK_POSCNT_EN
  logic [CNT_BW-1:0] pos_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pos_q <= '0;
    end else if (DE_in && label && (pos_q != '1)) begin
      pos_q <= pos_q + CNT_BW'(1);
    end
  end

  assign pos_count = pos_q;
`else
  assign pos_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_svm_label_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_svm_label_packer                                        |
// | Description : Self-checking bench for svm_label_packer: directed        |
// |               scenarios plus random traffic against a queue-based        |
// |               reference model.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_svm_label_packer;

  localparam int PW    = 16;
  localparam int DEPTH = 4;
  localparam int CBW   = 4;
  localparam int CW    = $clog2(PW + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           DE_in = 1'b0;
  logic           label = 1'b0;
  logic           flush = 1'b0;
  logic           out_ready = 1'b0;
  logic [PW-1:0]  out_data;
  logic [CW-1:0]  out_count;
  logic           out_valid;
  logic           overflow;
  logic [CBW-1:0] pos_count;

  svm_label_packer #(
    .PACK_W     (PW),
    .FIFO_DEPTH (DEPTH),
    .CNT_BW     (CBW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .DE_in     (DE_in),
    .label     (label),
    .flush     (flush),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .pos_count (pos_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] d;
    int            c;
  } word_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    lbits[$];
  word_t mq[$];
  bit    m_ovf = 1'b0;
  int    m_pos = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: labels collect in a bit list; a word is the weighted
  // sum of those bits; the FIFO is a queue of (data, count) pairs.
  task automatic model_edge(input bit rst_n, input bit de, input bit lab,
                            input bit fl, input bit rdy);
    word_t w;
    if (!rst_n) begin
      lbits.delete();
      mq.delete();
      m_ovf = 1'b0;
      m_pos = 0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (de) begin
        lbits.push_back(lab);
        if (lab && m_pos < (1 << CBW) - 1) m_pos++;
      end
      if (lbits.size() == PW || (fl && lbits.size() > 0)) begin
        w.d = '0;
        for (int k = 0; k < lbits.size(); k++) w.d = w.d + (PW'(lbits[k]) << k);
        w.c = lbits.size();
        if (mq.size() < DEPTH) mq.push_back(w);
        else m_ovf = 1'b1;
        lbits.delete();
      end
    end
  endtask

  task automatic step(input bit rst_n, input bit de, input bit lab,
                      input bit fl, input bit rdy);
    reset = rst_n; DE_in = de; label = lab; flush = fl; out_ready = rdy;
    @(posedge clk);
    model_edge(rst_n, de, lab, fl, rdy);
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    check_eq("out_data",  32'(out_data),  (mq.size() > 0) ? 32'(mq[0].d) : 32'd0);
    check_eq("out_count", 32'(out_count), (mq.size() > 0) ? 32'(mq[0].c) : 32'd0);
    check_eq("overflow",  32'(overflow),  32'(m_ovf));
`ifdef SVM_PACK_POSCNT_EN
    check_eq("pos_count", 32'(pos_count), 32'(m_pos));
`else
    check_eq("pos_count", 32'(pos_count), 32'd0);
`endif
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 1: alternating labels starting at 0 -> 16'h5555, valid for one cycle
    for (int i = 0; i < PW; i++) step(1'b1, 1'b1, bit'(i % 2 == 0), 1'b0, 1'b1);
    check_eq("alt_data",  32'(out_data), 32'h5555);
    check_eq("alt_count", 32'(out_count), 32'd16);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("alt_valid_drop", 32'(out_valid), 32'd0);

    // 2: partial word by flush, then flush with nothing pending
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("flush_data",  32'(out_data), 32'h0013);
    check_eq("flush_count", 32'(out_count), 32'd5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("empty_flush", 32'(out_valid), 32'd0);

    // Flush coinciding with a full-word accept
    for (int i = 0; i < PW - 1; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3: stalled consumer, five all-ones words -> overflow, four drain
    for (int i = 0; i < 5 * PW; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("drained", 32'(out_valid), 32'd0);

    // 4: full FIFO, pop coincides with the fifth word's completion
    do_reset();
    for (int i = 0; i < 5 * PW - 1; i++) step(1'b1, 1'b1, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("no_ovf", 32'(overflow), 32'd0);

    // 5: reset mid-word discards partial labels
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < PW; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("post_rst_data",  32'(out_data), 32'hFFFF);
    check_eq("post_rst_count", 32'(out_count), 32'd16);

    // 6: counter saturation (or constant zero when the feature is off)
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef SVM_PACK_POSCNT_EN
    check_eq("pos_sat", 32'(pos_count), 32'd15);
`else
    check_eq("pos_off", 32'(pos_count), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 199) != 0),
           bit'($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 11) == 0),
           bit'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/svm_label_packer.md
# svm_label_packer

- Downstream stage of the SVM classifier.
- Collects the one-bit `label` stream, qualified by the classifier's delayed data-enable `DE_out`, and packs labels LSB-first into `PACK_W`-bit words.
- Buffers packed words in a small first-word-fall-through FIFO and presents them on a valid/ready port to the host or bus interface.
- Partial words can be forced out with `flush`; dropped words are recorded in a sticky overflow flag.

## Interface

Parameters:
- `PACK_W`, 16 — labels per packed word (≥2).
- `FIFO_DEPTH`, 4 — FIFO entries (power of 2, ≥2).
- `CNT_BW`, 16 — width of the positive-label counter.

Ports:
- `clk`  in  1  — the single clock; all logic is on its rising edge.
- `reset`  in  1  — synchronous, active-low reset.
- `DE_in`  in  1  — label-valid; driven by classifier `DE_out`.
- `label`  in  1  — classifier label; sampled only when `DE_in`=1.
- `flush`  in  1  — one-cycle request to emit the current partial word.
- `out_data`  out  `PACK_W`  — FIFO head word; label k is in bit k.
- `out_count`  out  `$clog2(PACK_W+1)`  — number of valid label bits in `out_data`.
- `out_valid`  out  1  — FIFO non-empty.
- `out_ready`  in  1  — consumer accepts the head word when `out_valid`&`out_ready`.
- `overflow`  out  1  — sticky; a word was dropped because the FIFO was full.
- `pos_count`  out  `CNT_BW`  — count of accepted labels equal to 1 (see Configuration).

## Operation

- Packer state: `pack_reg[PACK_W-1:0]` and a fill counter `fill` ∈ 0..`PACK_W-1`.
- Accept: on an edge with `DE_in`=1, write `label` into bit `fill`, then increment `fill`.
- Full word: if the accept fills bit `PACK_W-1`:
  - enqueue {`label`, `pack_reg[PACK_W-2:0]`} with count `PACK_W` on the same edge;
  - clear `fill` and `pack_reg` to 0.
- Flush with pending bits: when `flush`=1 and (`fill`>0 or `DE_in`=1):
  - include the coincident label, if any;
  - enqueue the word with count = `fill` + `DE_in`;
  - unused upper bits are 0;
  - clear `fill` and `pack_reg` to 0.
- Flush with nothing pending: `flush`=1 with `fill`=0 and `DE_in`=0 has no effect. No zero-count word is enqueued.
- Flush on a full-word edge: `flush` coinciding with a full-word accept enqueues only the one full word.
- FIFO: first-word-fall-through, holding data plus count.
  - `out_data`/`out_count` show the head entry while `out_valid`=1, and read 0 when empty.
  - Pop on `out_valid`&`out_ready`.
- Simultaneous push and pop: when full, a pop and a push on the same edge both succeed; occupancy is unchanged and nothing is dropped.
- Push while full without a pop: the word is discarded, `overflow` is set, and the packer still clears. `overflow` clears only on reset.
- Reset (`reset`=0 at an edge), including mid-word:
  - clears `fill`, `pack_reg`, the FIFO pointers and occupancy, `overflow`, and `pos_count`;
  - inputs are ignored that cycle;
  - partial labels are lost.
- Reset values: `out_valid`=0, `out_data`=0, `out_count`=0, `overflow`=0, `pos_count`=0.

## Timing

- A label accepted at edge N that completes a word makes `out_valid`=1 in the cycle after edge N (latency 1).
- A flush at edge N gives `out_valid`=1 after edge N.
- A pop at edge M presents the next entry, or `out_valid`=0, after edge M.
- Throughput: one label per cycle sustained. With `out_ready` held high the FIFO never overflows.
- `out_data`/`out_count`/`out_valid` are registered-path outputs with no combinational path from `out_ready`.
- `overflow` asserts the cycle after the dropping edge.

## Configuration

- Macro: `SVM_PACK_POSCNT_EN`.
- Defined: `pos_count` increments by 1 on every edge where `DE_in`=1 and `label`=1.
  - It saturates at 2^`CNT_BW`−1.
  - Reset clears it; `flush` and FIFO state do not affect it.
- Undefined: the counter logic is omitted and `pos_count` is tied to 0. The port list is unchanged.

## Test plan

Test plan with `PACK_W`=16, `FIFO_DEPTH`=4, `out_ready`=1 unless stated:

1. Sixteen consecutive accepts with labels alternating 1,0,1,… starting at label 0 → one word `out_data`=16'h5555, `out_count`=16, `out_valid` high for exactly one cycle after the 16th accept.
2. Five accepts with labels 1,1,0,0,1, then `flush` alone → `out_data`=16'h0013, `out_count`=5. A second `flush` with `fill`=0 produces no word.
3. `out_ready`=0 and five full words of all-ones labels → four entries of 16'hFFFF held, `overflow`=1 after the 80th accept. Then `out_ready`=1 → exactly four words drain and `out_valid` drops.
4. FIFO full, then `out_ready`=1 on the same edge as a 16th accept → all five words delivered in order, `overflow` stays 0.
5. `reset`=0 after 7 accepts, then 16 accepts of label 1 → the first word out is 16'hFFFF with `out_count`=16; no stale bits appear.
6. With `SVM_PACK_POSCNT_EN` defined and `CNT_BW`=4: 20 accepts of label 1 → `pos_count` saturates at 15. Without the macro, `pos_count`=0 throughout.
